mem_arbiter: RTL

Shares the single read/write port of the data-memory controller between the core pipeline and one DMA requester. It sits between the core's memory-stage address/data outputs and the memory controller's port. DMA ownership stalls the core, and DMA bursts are bounded so the core is never starved. Read data for both owners is steered back with the memory's one-cycle read latency.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_burst_ctr.sv | 31 +++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner types and constants for mem_arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    CORE  = 2'd0,
    DMA   = 2'd1,
    YIELD = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    CORE_RD = 2'd1,
    DMA_RD  = 2'd2
  } owner_t;

  // Addresses below this hold SFR/IO registers that DMA may read but not write.
  localparam logic [7:0] SFR_LIMIT = 8'h10;

  localparam int unsigned BURST_W = 4;

  function automatic logic is_sfr(input logic [7:0] addr);
    return addr < SFR_LIMIT;
  endfunction

endpackage

// File: rtl/mem_arb_burst_ctr.sv
// mem_arb_burst_ctr: counts granted DMA transfers within one burst and flags
// the transfer that reaches MAX_BURST.
module mem_arb_burst_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic incr,
  output logic limit
);

  logic [BURST_W-1:0] count;

  // Burst count: held at zero outside DMA ownership, one step per transfer.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (incr) begin
      count <= count + 1'b1;
    end
  end

  // The current transfer completes the allowed burst.
  always_comb begin
    limit = incr && (({1'b0, count} + 5'd1) == 5'(MAX_BURST));
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the data-memory port between the core pipeline and one
// DMA requester, stalling the core while DMA owns the port and steering the
// one-cycle-latency read data back to its owner.
// Build option: MEM_ARBITER_BURST_LIMIT_EN enables the MAX_BURST limit and the
// YIELD state; without it DMA keeps the port while dma_req stays high.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] core_readaddr,
  input  logic [7:0] core_writeaddr,
  input  logic [7:0] core_writedata,
  input  logic       core_write_en,
  output logic [7:0] core_readdata,
  output logic       core_stall,
  input  logic       dma_req,
  input  logic       dma_we,
  input  logic [7:0] dma_addr,
  input  logic [7:0] dma_wdata,
  output logic       dma_gnt,
  output logic       dma_rvalid,
  output logic [7:0] dma_rdata,
  output logic       dma_err,
  output logic [7:0] mem_readaddr,
  output logic [7:0] mem_writeaddr,
  output logic [7:0] mem_writedata,
  output logic       mem_write_en,
  input  logic [7:0] mem_readdata
);

  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
    $error("mem_arbiter: MAX_BURST must be in 1..15");
  end

  arb_state_t state, state_next;
  owner_t     owner_q, owner_next;
  logic [7:0] hold_q;
  logic       err_q;
  logic       burst_limit;
  logic       burst_clear;

  assign burst_clear = (state != DMA);

`ifdef MEM_ARBITER_BURST_LIMIT_EN
  mem_arb_burst_ctr #(.MAX_BURST(MAX_BURST)) u_burst_ctr (
    .clk   (clk),
    .reset (reset),
    .clear (burst_clear),
    .incr  (dma_gnt),
    .limit (burst_limit)
  );
`else
  assign burst_limit = 1'b0;
`endif

  // Ownership state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CORE;
    end else begin
      state <= state_next;
    end
  end

  // Next ownership and port mux; CORE and YIELD both hand the port to the core.
  always_comb begin
    state_next    = state;
    core_stall    = 1'b0;
    dma_gnt       = 1'b0;
    mem_readaddr  = core_readaddr;
    mem_writeaddr = core_writeaddr;
    mem_writedata = core_writedata;
    mem_write_en  = core_write_en;
    case (state)
      CORE, YIELD: begin
        state_next = dma_req ? DMA : CORE;
      end
      DMA: begin
        core_stall    = 1'b1;
        dma_gnt       = dma_req;
        mem_readaddr  = dma_addr;
        mem_writeaddr = dma_addr;
        mem_writedata = dma_wdata;
        mem_write_en  = dma_req && dma_we && !is_sfr(dma_addr);
        if (!dma_req) begin
          state_next = CORE;
        end else if (burst_limit) begin
          state_next = YIELD;
        end
      end
      default: begin
        state_next = CORE;
      end
    endcase
  end

  // Who owns the read data arriving next cycle.
  always_comb begin
    owner_next = NONE;
    if (state != DMA) begin
      owner_next = CORE_RD;
    end else if (dma_gnt && !dma_we) begin
      owner_next = DMA_RD;
    end
  end

  // Read owner, core hold register and dropped-write flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= NONE;
      hold_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      owner_q <= owner_next;
      err_q   <= dma_gnt && dma_we && is_sfr(dma_addr);
      // Last core read result arrives in the first stalled cycle; keep it.
      if (owner_q == CORE_RD && state == DMA) begin
        hold_q <= mem_readdata;
      end
    end
  end

  // Read data steering.
  always_comb begin
    dma_rvalid    = (owner_q == DMA_RD);
    dma_rdata     = dma_rvalid ? mem_readdata : '0;
    core_readdata = (owner_q == CORE_RD) ? mem_readdata : hold_q;
    dma_err       = err_q;
  end

endmodule
